// File: rtl/motoro3_pkg.sv
// Shared constants and state encoding for the motoro3 step sequencer slice.
package motoro3_pkg;

  localparam int unsigned CNT_W_DEF        = 25;
  localparam int unsigned REV_W_DEF        = 16;
  localparam int unsigned MIN_STEP_LEN_DEF = 4;
  localparam int unsigned STEP_W           = 4;

  localparam logic [STEP_W-1:0] STEP_LAST = 4'd11;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } seq_state_e;

endpackage

// File: rtl/motoro3_step_len_ramp.sv
// Combinational next-step length: clamped target, optionally approached by an
// acceleration ramp when MOTORO3_STEP_ACCEL_EN is defined.
module motoro3_step_len_ramp
  import motoro3_pkg::*;
#(
  parameter int unsigned CNT_W        = CNT_W_DEF,
  parameter int unsigned MIN_STEP_LEN = MIN_STEP_LEN_DEF
) (
`ifdef MOTORO3_STEP_ACCEL_EN
  input  logic [CNT_W-1:0] len_i,
  input  logic [15:0]      accel_delta_i,
`endif
  input  logic [CNT_W-1:0] step_len_i,
  output logic [CNT_W-1:0] len_new_o
);

  localparam logic [CNT_W-1:0] MIN_L = CNT_W'(MIN_STEP_LEN);

  logic [CNT_W-1:0] target;
`ifdef MOTORO3_STEP_ACCEL_EN
  logic [CNT_W-1:0] accel;
  logic [CNT_W-1:0] dec;
`endif

  always_comb begin
    target = (step_len_i < MIN_L) ? MIN_L : step_len_i;
`ifdef MOTORO3_STEP_ACCEL_EN
    // Saturating shrink toward target; a longer target is taken at once.
    accel     = CNT_W'(accel_delta_i);
    dec       = (len_i > accel) ? (len_i - accel) : '0;
    len_new_o = (dec > target) ? dec : target;
`else
    len_new_o = target;
`endif
  end

endmodule

// File: rtl/motoro3_step_sequencer.sv
// 12-step commutation sequencer with per-step down-counter, edge strobes and
// revolution-counted start/stop/abort control. Optional ramp: MOTORO3_STEP_ACCEL_EN.
module motoro3_step_sequencer
  import motoro3_pkg::*;
#(
  parameter int unsigned CNT_W        = CNT_W_DEF,
  parameter int unsigned REV_W        = REV_W_DEF,
  parameter int unsigned MIN_STEP_LEN = MIN_STEP_LEN_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                stop,
  input  logic                abort,
  input  logic [CNT_W-1:0]    stepLen,
  input  logic [REV_W-1:0]    revMax,
`ifdef MOTORO3_STEP_ACCEL_EN
  input  logic [CNT_W-1:0]    stepLenStart,
  input  logic [15:0]         accelDelta,
`endif
  output logic [STEP_W-1:0]   sgStep,
  output logic [CNT_W-1:0]    m3cnt,
  output logic                m3cntFirst2,
  output logic                m3cntFirst1,
  output logic                m3cntLast1,
  output logic                m3cntLast2,
  output logic                pwmActive1,
  output logic                pwmLastStep1,
  output logic                busy,
  output logic                done
);

  localparam logic [CNT_W-1:0]  MIN_L    = CNT_W'(MIN_STEP_LEN);
  localparam logic [STEP_W-1:0] STEP_PRE = STEP_LAST - 4'd1;

  seq_state_e        state_q, state_d;
  logic [CNT_W-1:0]  len_q, len_d;
  logic [REV_W-1:0]  rev_q, rev_d;
  logic              pend_q, pend_d;
  logic [STEP_W-1:0] step_q, step_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              last_q, last_d;
  logic              done_q, done_d;
  logic              f2_q, f2_d, f1_q, f1_d, l1_q, l1_d, l2_q, l2_d;

  logic [CNT_W-1:0]  start_raw;
  logic [CNT_W-1:0]  start_len;
  logic [CNT_W-1:0]  len_new;

`ifdef MOTORO3_STEP_ACCEL_EN
  assign start_raw = stepLenStart;
`else
  assign start_raw = stepLen;
`endif
  assign start_len = (start_raw < MIN_L) ? MIN_L : start_raw;

  motoro3_step_len_ramp #(
    .CNT_W        (CNT_W),
    .MIN_STEP_LEN (MIN_STEP_LEN)
  ) u_ramp (
`ifdef MOTORO3_STEP_ACCEL_EN
    .len_i         (len_q),
    .accel_delta_i (accelDelta),
`endif
    .step_len_i    (stepLen),
    .len_new_o     (len_new)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      len_q   <= MIN_L;
      rev_q   <= '0;
      pend_q  <= 1'b0;
      step_q  <= '0;
      cnt_q   <= '0;
      last_q  <= 1'b0;
      done_q  <= 1'b0;
      f2_q    <= 1'b0;
      f1_q    <= 1'b0;
      l1_q    <= 1'b0;
      l2_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      rev_q   <= rev_d;
      pend_q  <= pend_d;
      step_q  <= step_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
      done_q  <= done_d;
      f2_q    <= f2_d;
      f1_q    <= f1_d;
      l1_q    <= l1_d;
      l2_q    <= l2_d;
    end
  end

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    rev_d   = rev_q;
    pend_d  = pend_q;
    step_d  = step_q;
    cnt_d   = cnt_q;
    last_d  = last_q;
    done_d  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_RUN;
          len_d   = start_len;
          rev_d   = revMax;
          pend_d  = (revMax == REV_W'(1));
          step_d  = '0;
          cnt_d   = start_len - CNT_W'(1);
          last_d  = 1'b0;
        end
      end
      ST_RUN: begin
        if (abort) begin
          state_d = ST_IDLE;
          len_d   = MIN_L;
          rev_d   = '0;
          pend_d  = 1'b0;
          step_d  = '0;
          cnt_d   = '0;
          last_d  = 1'b0;
        end else begin
          if (stop) pend_d = 1'b1;
          if (cnt_q == '0) begin
            if (last_q) begin
              state_d = ST_IDLE;
              pend_d  = 1'b0;
              step_d  = '0;
              cnt_d   = '0;
              last_d  = 1'b0;
              done_d  = 1'b1;
            end else begin
              len_d = len_new;
              cnt_d = len_new - CNT_W'(1);
              if (step_q == STEP_LAST) begin
                // Revolution wrap: count down, arm stop when one revolution remains.
                step_d = '0;
                last_d = 1'b0;
                if (rev_q != '0) rev_d = rev_q - REV_W'(1);
                if (rev_q == REV_W'(2)) pend_d = 1'b1;
              end else begin
                step_d = step_q + STEP_W'(1);
                last_d = (step_q == STEP_PRE) && pend_q;
              end
            end
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Strobes decode the next count so they line up with the registered m3cnt.
    f2_d = (state_d == ST_RUN) && (cnt_d == len_d - CNT_W'(1));
    f1_d = (state_d == ST_RUN) && (cnt_d == len_d - CNT_W'(2));
    l1_d = (state_d == ST_RUN) && (cnt_d == CNT_W'(1));
    l2_d = (state_d == ST_RUN) && (cnt_d == '0);
  end

  assign sgStep       = step_q;
  assign m3cnt        = cnt_q;
  assign m3cntFirst2  = f2_q;
  assign m3cntFirst1  = f1_q;
  assign m3cntLast1   = l1_q;
  assign m3cntLast2   = l2_q;
  assign pwmActive1   = (state_q == ST_RUN);
  assign busy         = (state_q == ST_RUN);
  assign pwmLastStep1 = last_q;
  assign done         = done_q;

endmodule

// File: tb/tb_motoro3_step_sequencer.sv
// Scoreboard bench for motoro3_step_sequencer: expected per-cycle outputs are
// queued with a cycle stamp and checked by an independent monitor.
module tb_motoro3_step_sequencer;

  localparam int unsigned CW = 25;
  localparam int unsigned RW = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0, stop = 1'b0, abort = 1'b0;
  logic [CW-1:0] stepLen = '0;
  logic [RW-1:0] revMax = '0;
`ifdef MOTORO3_STEP_ACCEL_EN
  logic [CW-1:0] stepLenStart = '0;
  logic [15:0]   accelDelta = '0;
`endif
  logic [3:0]    sgStep;
  logic [CW-1:0] m3cnt;
  logic          m3cntFirst2, m3cntFirst1, m3cntLast1, m3cntLast2;
  logic          pwmActive1, pwmLastStep1, busy, done;
  logic [7:0]    got_flags;

  motoro3_step_sequencer dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .stop         (stop),
    .abort        (abort),
    .stepLen      (stepLen),
    .revMax       (revMax),
`ifdef MOTORO3_STEP_ACCEL_EN
    .stepLenStart (stepLenStart),
    .accelDelta   (accelDelta),
`endif
    .sgStep       (sgStep),
    .m3cnt        (m3cnt),
    .m3cntFirst2  (m3cntFirst2),
    .m3cntFirst1  (m3cntFirst1),
    .m3cntLast1   (m3cntLast1),
    .m3cntLast2   (m3cntLast2),
    .pwmActive1   (pwmActive1),
    .pwmLastStep1 (pwmLastStep1),
    .busy         (busy),
    .done         (done)
  );

  assign got_flags = {m3cntFirst2, m3cntFirst1, m3cntLast1, m3cntLast2,
                      pwmActive1, pwmLastStep1, busy, done};

  always #50 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         stamp;
    int         tid;
    logic [3:0] step;
    logic [CW-1:0] cnt;
    logic [7:0] flags;
  } exp_t;

  exp_t sb_q[$];
  int   lens_q[$];
  int   total = 0;
  int   bad = 0;

  // Monitor: pops every expectation due this cycle and compares.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      while (sb_q.size() > 0 && sb_q[0].stamp <= cyc) begin
        e = sb_q.pop_front();
        total++;
        if (e.stamp != cyc || sgStep !== e.step || m3cnt !== e.cnt || got_flags !== e.flags) begin
          bad++;
          $display("FAIL t%0d cyc=%0d due=%0d: got step=%0d cnt=%0d f2f1l1l2/act/last/busy/done=%b, want step=%0d cnt=%0d flags=%b",
                   e.tid, cyc, e.stamp, sgStep, m3cnt, got_flags, e.step, e.cnt, e.flags);
        end
      end
    end
  end

  task automatic push(input int s, input int tid, input int step, input int cnt, input logic [7:0] fl);
    exp_t e;
    e.stamp = s;
    e.tid   = tid;
    e.step  = 4'(step);
    e.cnt   = CW'(cnt);
    e.flags = fl;
    sb_q.push_back(e);
  endtask

  task automatic push_idle(input int s, input int tid, input logic d);
    push(s, tid, 0, 0, {7'b0, d});
  endtask

  task automatic fill(input int len, input int n);
    repeat (n) lens_q.push_back(len);
  endtask

  // Expected run from the per-step lengths in lens_q; limit < 0 means whole run.
  task automatic exp_seq(input int base, input int tid, input int last_g, input int limit, output int n);
    int k;
    k = 0;
    for (int g = 0; g < lens_q.size(); g++) begin
      for (int c = 0; c < lens_q[g]; c++) begin
        if (limit < 0 || k < limit) begin
          int cnt;
          cnt = lens_q[g] - 1 - c;
          push(base + k, tid, g % 12, cnt,
               {(c == 0), (c == 1), (cnt == 1), (cnt == 0), 1'b1, (g == last_g), 1'b1, 1'b0});
          k++;
        end
      end
    end
    n = k;
  endtask

  task automatic wait_until(input int s);
    while (cyc < s) @(negedge clk);
  endtask

  task automatic do_start(input int sl_start, input int sl, input int rm);
    stepLen = CW'(sl);
    revMax  = RW'(rm);
`ifdef MOTORO3_STEP_ACCEL_EN
    stepLenStart = CW'(sl_start);
`else
    if (sl_start < 0) stepLen = CW'(sl);
`endif
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic pulse_stop();
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
  endtask

  initial begin
    int b, base, n;

    // Reset, then stop/abort in IDLE have no effect.
    @(negedge clk);
    b = cyc + 1;
    for (int i = 0; i < 4; i++) push_idle(b + i, 0, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    stop = 1'b1;
    abort = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    abort = 1'b0;
    wait_until(b + 4);

    // T1: stepLen 10, one revolution; start during RUN ignored.
    lens_q.delete(); fill(10, 12);
    base = cyc + 1;
    exp_seq(base, 1, 11, -1, n);
    push_idle(base + n, 1, 1'b1);
    push_idle(base + n + 1, 1, 1'b0);
    do_start(10, 10, 1);
    wait_until(base + 50);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_until(base + n + 2);

    // T2: stepLen below minimum clamps to 4.
    lens_q.delete(); fill(4, 12);
    base = cyc + 1;
    exp_seq(base, 2, 11, -1, n);
    push_idle(base + n, 2, 1'b1);
    push_idle(base + n + 1, 2, 1'b0);
    do_start(2, 2, 1);
    wait_until(base + n + 2);

    // T3: continuous run, stop during step 4 of revolution 2.
    lens_q.delete(); fill(8, 24);
    base = cyc + 1;
    exp_seq(base, 3, 23, -1, n);
    push_idle(base + n, 3, 1'b1);
    push_idle(base + n + 1, 3, 1'b0);
    do_start(8, 8, 0);
    wait_until(base + 16 * 8 + 3);
    pulse_stop();
    wait_until(base + n + 2);

    // T4: stop mid step 11 defers to the next revolution's step 11.
    lens_q.delete(); fill(8, 24);
    base = cyc + 1;
    exp_seq(base, 4, 23, -1, n);
    push_idle(base + n, 4, 1'b1);
    push_idle(base + n + 1, 4, 1'b0);
    do_start(8, 8, 0);
    wait_until(base + 11 * 8 + 3);
    pulse_stop();
    wait_until(base + n + 2);

    // T5: abort in step 5 at m3cnt 3, then a clean restart.
    lens_q.delete(); fill(8, 12);
    base = cyc + 1;
    exp_seq(base, 5, -1, 45, n);
    push_idle(base + 45, 5, 1'b0);
    push_idle(base + 46, 5, 1'b0);
    do_start(8, 8, 0);
    wait_until(base + 44);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    wait_until(base + 47);
    lens_q.delete(); fill(6, 12);
    base = cyc + 1;
    exp_seq(base, 6, 11, -1, n);
    push_idle(base + n, 6, 1'b1);
    push_idle(base + n + 1, 6, 1'b0);
    do_start(6, 6, 1);
    wait_until(base + n + 2);

    // T6: stepLen 10 -> 20 mid step 3 takes effect from step 4.
    lens_q.delete(); fill(10, 4); fill(20, 8);
    base = cyc + 1;
    exp_seq(base, 7, 11, -1, n);
    push_idle(base + n, 7, 1'b1);
    push_idle(base + n + 1, 7, 1'b0);
    do_start(10, 10, 1);
    wait_until(base + 35);
    stepLen = CW'(20);
    wait_until(base + n + 2);

`ifdef MOTORO3_STEP_ACCEL_EN
    // T7: acceleration ramp 100, 70, 40, then 20.
    lens_q.delete(); fill(100, 1); fill(70, 1); fill(40, 1); fill(20, 9);
    base = cyc + 1;
    exp_seq(base, 8, 11, -1, n);
    push_idle(base + n, 8, 1'b1);
    push_idle(base + n + 1, 8, 1'b0);
    accelDelta = 16'd30;
    do_start(100, 20, 1);
    wait_until(base + n + 2);
    accelDelta = 16'd0;
`endif

    // T8: reset mid-run returns to the power-on state.
    lens_q.delete(); fill(5, 12);
    base = cyc + 1;
    exp_seq(base, 9, -1, 7, n);
    push_idle(base + 7, 9, 1'b0);
    push_idle(base + 8, 9, 1'b0);
    do_start(5, 5, 0);
    wait_until(base + 6);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    wait_until(base + 9);

    for (int i = 0; i < 100 && sb_q.size() > 0; i++) @(negedge clk);
    if (sb_q.size() > 0) begin
      total++;
      bad++;
      $display("FAIL drain: got %0d pending expectations, want 0", sb_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
